// File: rtl/id_inst_queue_if.sv
// Handshake bundle between IF/inst-SRAM (producer), the decode instruction queue and ID (consumer).
// The master modport is the IF/ID side that drives the queue; the slave modport is the queue itself.
interface id_inst_queue_if #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32
);
   logic              in_valid;
   logic [PC_W-1:0]   in_pc;
   logic [INST_W-1:0] in_inst;
   logic              in_ready;
   logic              out_valid;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;
   logic              out_ready;
   logic              flush;
   logic              keep_slot;

   modport master (
      output in_valid, in_pc, in_inst, out_ready, flush, keep_slot,
      input  in_ready, out_valid, out_pc, out_inst
   );

   modport slave (
      input  in_valid, in_pc, in_inst, out_ready, flush, keep_slot,
      output in_ready, out_valid, out_pc, out_inst
   );
endinterface

// File: rtl/id_inst_queue.sv
// Decode-side FIFO of {pc, inst} pairs with branch flush (optional delay-slot keep) and sticky overflow.
// Define ID_IQ_BYPASS_EN for a zero-latency empty-queue bypass from in_* to out_*.
module id_inst_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned PC_W      = 32,
   parameter int unsigned INST_W    = 32,
   parameter int unsigned AF_MARGIN = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   id_inst_queue_if.slave             q,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       almost_full,
   output logic                       ovf_err
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] AF_TH = CNT_W'(DEPTH - AF_MARGIN);

   logic [PC_W-1:0]   mem_pc   [DEPTH];
   logic [INST_W-1:0] mem_inst [DEPTH];

   logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nx, wr_ptr_nx;
   logic [CNT_W-1:0] count_q, count_nx, remain;
   logic             empty, push, pop_mem, wr_en, bypass, ovf_q;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CNT_W'(DEPTH));
   assign almost_full = (count_q >= AF_TH);
   assign count       = count_q;
   assign ovf_err     = ovf_q;

   assign q.in_ready = ~full;
   assign push       = q.in_valid & ~full;
   assign pop_mem    = ~empty & q.out_ready;

`ifdef ID_IQ_BYPASS_EN
   assign bypass = empty & q.in_valid & ~q.flush;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      q.out_valid = ~empty | bypass;
      q.out_pc    = '0;
      q.out_inst  = '0;
      if (bypass) begin
         q.out_pc   = q.in_pc;
         q.out_inst = q.in_inst;
      end else if (!empty) begin
         q.out_pc   = mem_pc[rd_ptr];
         q.out_inst = mem_inst[rd_ptr];
      end
   end

   always_comb begin
      rd_ptr_nx = rd_ptr;
      wr_ptr_nx = wr_ptr;
      count_nx  = count_q;
      wr_en     = 1'b0;
      remain    = count_q - CNT_W'(pop_mem);
      if (q.flush) begin
         // Pop first; with nothing left, rd_ptr_nx equals wr_ptr so a same-cycle
         // push written at wr_ptr lands exactly at the new head.
         rd_ptr_nx = rd_ptr + PTR_W'(pop_mem);
         if (q.keep_slot && (remain != '0 || push)) begin
            count_nx  = CNT_W'(1);
            wr_ptr_nx = rd_ptr_nx + PTR_W'(1);
            wr_en     = (remain == '0) & push;
         end else begin
            count_nx  = '0;
            wr_ptr_nx = rd_ptr_nx;
         end
      end else begin
         wr_en = push & ~(bypass & q.out_ready);
         if (wr_en)   wr_ptr_nx = wr_ptr + PTR_W'(1);
         if (pop_mem) rd_ptr_nx = rd_ptr + PTR_W'(1);
         count_nx = count_q + CNT_W'(wr_en) - CNT_W'(pop_mem);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_pc[wr_ptr]   <= q.in_pc;
         mem_inst[wr_ptr] <= q.in_inst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         rd_ptr  <= rd_ptr_nx;
         wr_ptr  <= wr_ptr_nx;
         count_q <= count_nx;
         ovf_q   <= ovf_q | (q.in_valid & full);
      end
   end
endmodule

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue (DEPTH=4): vector table, flush corner sequences and a
// scoreboarded random push/pop run.
module tb_id_inst_queue;
   localparam int unsigned DEPTH = 4;
`ifdef ID_IQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] count;
   logic       full, almost_full, ovf_err;
   int         tests = 0;
   int         fails = 0;

   id_inst_queue_if #(.PC_W(32), .INST_W(32)) bus ();

   id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .AF_MARGIN(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .q           (bus),
      .count       (count),
      .full        (full),
      .almost_full (almost_full),
      .ovf_err     (ovf_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, iv;
      logic [31:0] pc, inst;
      logic        ordy, fl, ks;
      logic        e_ov;
      logic [31:0] e_pc, e_inst;
      logic [2:0]  e_cnt;
      logic        e_full, e_af, e_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic iv, logic [31:0] pc, logic [31:0] inst, logic ordy,
                               logic ov, logic [31:0] epc, logic [31:0] einst, logic [2:0] cnt,
                               logic fu, logic af, logic ovf);
      vec_t v;
      v.rst = r; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy; v.fl = 1'b0; v.ks = 1'b0;
      v.e_ov = ov; v.e_pc = epc; v.e_inst = einst; v.e_cnt = cnt;
      v.e_full = fu; v.e_af = af; v.e_ovf = ovf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy, input logic fl, input logic ks);
      bus.in_valid  = iv;
      bus.in_pc     = pc;
      bus.in_inst   = inst;
      bus.out_ready = ordy;
      bus.flush     = fl;
      bus.keep_slot = ks;
   endtask

   // Apply one cycle of stimulus, then return inputs to idle so outputs reflect registered state only.
   task automatic step(input logic iv, input logic [31:0] pc, input logic ordy,
                       input logic fl, input logic ks);
      @(negedge clk);
      drive(iv, pc, pc ^ 32'h1234_0000, ordy, fl, ks);
      @(posedge clk);
      #1 drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   logic [63:0] sb[$];
   logic [63:0] hd;
   logic        exp_ov, acc;
   logic [31:0] pc_r;
   int          npush;

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int unsigned i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int unsigned i = 0; i < 4; i++)
         vecs.push_back(mk(0, 1, 32'h3000 + 4 * i, 32'h2408_0001 + i, 0,
                           1, 32'h3000, 32'h2408_0001, 3'(i + 1), i == 3, i >= 2, 0));
      vecs.push_back(mk(0, 1, 32'h3010, 32'h2408_0005, 0, 1, 32'h3000, 32'h2408_0001, 4, 1, 1, 1));
      vecs.push_back(mk(0, 1, 32'h3010, 32'h2408_0005, 1, 1, 32'h3004, 32'h2408_0002, 3, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h3008, 32'h2408_0003, 2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h300C, 32'h2408_0004, 1, 0, 0, 1));
      vecs.push_back(mk(0, 1, 32'h3100, 32'hAAAA_0001, 1, 1, 32'h3100, 32'hAAAA_0001, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      foreach (vecs[k]) begin
         @(negedge clk);
         rst = vecs[k].rst;
         drive(vecs[k].iv, vecs[k].pc, vecs[k].inst, vecs[k].ordy, vecs[k].fl, vecs[k].ks);
         @(posedge clk);
         #1 drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
         rst = 1'b0;
         #1;
         chk($sformatf("v%0d out_valid", k), 32'(bus.out_valid), 32'(vecs[k].e_ov));
         chk($sformatf("v%0d out_pc", k), bus.out_pc, vecs[k].e_pc);
         chk($sformatf("v%0d out_inst", k), bus.out_inst, vecs[k].e_inst);
         chk($sformatf("v%0d count", k), 32'(count), 32'(vecs[k].e_cnt));
         chk($sformatf("v%0d full", k), 32'(full), 32'(vecs[k].e_full));
         chk($sformatf("v%0d almost_full", k), 32'(almost_full), 32'(vecs[k].e_af));
         chk($sformatf("v%0d ovf_err", k), 32'(ovf_err), 32'(vecs[k].e_ovf));
      end

      // Retained flush with concurrent pop: oldest remaining entry survives.
      step(1, 32'h3000, 0, 0, 0);
      step(1, 32'h3004, 0, 0, 0);
      step(1, 32'h3008, 0, 0, 0);
      step(0, 0, 1, 1, 1);
      chk("keep count", 32'(count), 1);
      chk("keep head", bus.out_pc, 32'h3004);
      step(0, 0, 1, 0, 0);
      chk("keep drain", 32'(count), 0);
      step(1, 32'h3000, 0, 0, 0);
      step(1, 32'h3004, 0, 0, 0);
      step(1, 32'h3008, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      chk("flush count", 32'(count), 0);
      chk("flush valid", 32'(bus.out_valid), 0);
      step(1, 32'h5000, 0, 0, 0);
      chk("post-flush head", bus.out_pc, 32'h5000);
      chk("post-flush count", 32'(count), 1);
      step(0, 0, 1, 1, 0);

      // Flush on empty queue with a same-cycle push.
      step(1, 32'h4000, 0, 1, 1);
      chk("empty keep count", 32'(count), 1);
      chk("empty keep head", bus.out_pc, 32'h4000);
      chk("empty keep inst", bus.out_inst, 32'h4000 ^ 32'h1234_0000);
      step(0, 0, 0, 1, 0);
      step(1, 32'h4000, 0, 1, 0);
      chk("empty flush count", 32'(count), 0);
      chk("empty flush ovf", 32'(ovf_err), 0);

      // Empty queue, push and consume in the same cycle.
      @(negedge clk);
      drive(1'b1, 32'h6000, 32'h6666_0000, 1'b1, 1'b0, 1'b0);
      #1;
      chk("same-cycle out_valid", 32'(bus.out_valid), 32'(BYP));
      chk("same-cycle out_pc", bus.out_pc, BYP ? 32'h6000 : 32'h0);
      @(posedge clk);
      #1 drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("same-cycle count", 32'(count), BYP ? 32'd0 : 32'd1);
      if (!BYP) step(0, 0, 1, 0, 0);

      // Random push/pop against a scoreboard; enough pushes to wrap the pointers several times.
      do_reset();
      pc_r  = 32'h7000;
      npush = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         drive($urandom_range(9, 0) < 7, pc_r, pc_r ^ 32'h00F0_0000,
               $urandom_range(9, 0) < 6, 1'b0, 1'b0);
         #1;
         exp_ov = (sb.size() > 0) || (BYP && bus.in_valid);
         hd     = (sb.size() > 0) ? sb[0] : (exp_ov ? {bus.in_pc, bus.in_inst} : 64'h0);
         chk("rnd in_ready", 32'(bus.in_ready), 32'(sb.size() < DEPTH));
         chk("rnd out_valid", 32'(bus.out_valid), 32'(exp_ov));
         chk("rnd out_pc", bus.out_pc, hd[63:32]);
         chk("rnd out_inst", bus.out_inst, hd[31:0]);
         acc = bus.in_valid && (sb.size() < DEPTH);
         @(posedge clk);
         if (acc) begin
            sb.push_back({bus.in_pc, bus.in_inst});
            pc_r = pc_r + 4;
            npush++;
         end
         if (exp_ov && bus.out_ready) void'(sb.pop_front());
         #1;
         chk("rnd count", 32'(count), 32'(sb.size()));
      end
      chk("rnd wrapped", 32'(npush >= 3 * DEPTH), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
